// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: datapath width and the 4-bit operation encoding.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        AND      = 4'b0000,
        OR       = 4'b0001,
        ADD      = 4'b0010,
        XOR      = 4'b0011,
        SLL      = 4'b0100,
        SRL      = 4'b0101,
        SUB      = 4'b0110,
        SLT      = 4'b0111,
        SLTU     = 4'b1000,
        SRA      = 4'b1001,
        PASSB    = 4'b1010,
        NAND     = 4'b1011,
        NOR      = 4'b1100,
        XNOR     = 4'b1101,
        PASSA    = 4'b1110,
        RESERVED = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_suma_c2.sv
// 32-bit two's-complement adder with carry-in/carry-out, shared by ADD and SUB.
module suma_c2
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] wide_sum_s;

    assign wide_sum_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign sum        = wide_sum_s[DATA_W-1:0];
    assign cout       = wide_sum_s[DATA_W];

endmodule

// File: rtl/alu.sv
// 32-bit ALU: combinational operation mux followed by a single output register stage.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALU_Sel,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              coutfin,
    output logic              z
);

    alu_op_e             op_s;
    logic                is_sub_s;
    logic [DATA_W-1:0]   add_b_s;
    logic [DATA_W-1:0]   add_sum_s;
    logic                add_cout_s;
    logic [SHAMT_W-1:0]  shamt_s;
    logic [DATA_W-1:0]   result_s;
    logic                carry_s;
    logic [DATA_W-1:0]   out_r;
    logic                cout_r;
    logic                z_r;

    assign op_s     = alu_op_e'(ALU_Sel);
    assign is_sub_s = (ALU_Sel == 4'(SUB));
    assign add_b_s  = is_sub_s ? ~B : B;
    assign shamt_s  = B[SHAMT_W-1:0];

    // SUB reuses the adder as A + ~B + 1.
    suma_c2 u_suma_c2 (
        .a    (A),
        .b    (add_b_s),
        .cin  (is_sub_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Operation select; carry is only meaningful for ADD/SUB.
    always_comb begin
        result_s = {DATA_W{1'b0}};
        carry_s  = 1'b0;
        case (op_s)
            AND:   result_s = A & B;
            OR:    result_s = A | B;
            ADD: begin
                result_s = add_sum_s;
                carry_s  = add_cout_s;
            end
            XOR:   result_s = A ^ B;
            SLL:   result_s = A << shamt_s;
            SRL:   result_s = A >> shamt_s;
            SUB: begin
                result_s = add_sum_s;
                carry_s  = add_cout_s;
            end
            SLT:   result_s = ($signed(A) < $signed(B)) ? 32'h0000_0001 : 32'h0000_0000;
            SLTU:  result_s = (A < B) ? 32'h0000_0001 : 32'h0000_0000;
            SRA:   result_s = $unsigned($signed(A) >>> shamt_s);
            PASSB: result_s = B;
            NAND:  result_s = ~(A & B);
            NOR:   result_s = ~(A | B);
            XNOR:  result_s = ~(A ^ B);
            PASSA: result_s = A;
            default: begin
                result_s = {DATA_W{1'b0}};
                carry_s  = 1'b0;
            end
        endcase
    end

    // Output register; z is derived from the same value being registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= {DATA_W{1'b0}};
            cout_r <= 1'b0;
            z_r    <= 1'b0;
        end else begin
            out_r  <= result_s;
            cout_r <= carry_s;
            z_r    <= (result_s == {DATA_W{1'b0}});
        end
    end

    assign ALU_Out = out_r;
    assign coutfin = cout_r;
    assign z       = z_r;

endmodule

// File: tb/tb_alu.sv
// Directed-vector testbench for alu with hand-computed expected values.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Sel;
    logic [31:0] ALU_Out;
    logic        coutfin;
    logic        z;

    int total;
    int bad;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out),
        .coutfin (coutfin),
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive inputs away from the active edge, then sample 1 time unit after it.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_Sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [31:0] o, input logic c, input logic zz);
        check({tag, ".out"}, ALU_Out, o);
        check({tag, ".cout"}, {31'd0, coutfin}, {31'd0, c});
        check({tag, ".z"}, {31'd0, z}, {31'd0, zz});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        A       = 32'h1234_5678;
        B       = 32'h0000_0001;
        ALU_Sel = 4'b0010;
        #12;
        expect3("reset", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect3("reset_clk", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b0010);
        expect3("add", 32'hBE02_4677, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b0110);
        expect3("sub", 32'h9999_9987, 1'b1, 1'b0);
        apply(32'h0000_0005, 32'h0000_0005, 4'b0110);
        expect3("sub_eq", 32'h0, 1'b1, 1'b1);
        apply(32'h0000_0004, 32'h0000_0005, 4'b0110);
        expect3("sub_lt", 32'hFFFF_FFFF, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b0000);
        expect3("and", 32'h0204_4678, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b0001);
        expect3("or", 32'hBBFD_FFFF, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b0011);
        expect3("xor", 32'hB9F9_B987, 1'b0, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010);
        expect3("add_wrap", 32'h0, 1'b1, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
        expect3("slt", 32'h1, 1'b0, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0001, 4'b1000);
        expect3("sltu", 32'h0, 1'b0, 1'b1);
        apply(32'h8000_0000, 32'h0000_0004, 4'b1001);
        expect3("sra", 32'hF800_0000, 1'b0, 1'b0);
        apply(32'h8000_0000, 32'h0000_0004, 4'b0101);
        expect3("srl", 32'h0800_0000, 1'b0, 1'b0);
        apply(32'h8000_0000, 32'h0000_0004, 4'b0100);
        expect3("sll", 32'h0, 1'b0, 1'b1);
        apply(32'h0000_0003, 32'hFFFF_FFE4, 4'b0100);
        expect3("sll_hi_ignored", 32'h0000_0030, 1'b0, 1'b0);
        apply(32'h4000_0000, 32'h0000_0001, 4'b1001);
        expect3("sra_pos", 32'h2000_0000, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1010);
        expect3("passb", 32'h1234_5678, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1011);
        expect3("nand", 32'hFDFB_B987, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1100);
        expect3("nor", 32'h4402_0000, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1101);
        expect3("xnor", 32'h4606_4678, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1110);
        expect3("passa", 32'hABCD_EFFF, 1'b0, 1'b0);
        apply(32'hABCD_EFFF, 32'h1234_5678, 4'b1111);
        expect3("reserved", 32'h0, 1'b0, 1'b1);
        apply(32'h8000_0000, 32'h0000_0001, 4'b0111);
        expect3("slt_neg", 32'h1, 1'b0, 1'b0);
        apply(32'h8000_0000, 32'h0000_0001, 4'b1000);
        expect3("sltu_big", 32'h0, 1'b0, 1'b1);

        // Mid-cycle reset while an ADD result is held.
        apply(32'hFFFF_FFFF, 32'h0000_0002, 4'b0010);
        expect3("pre_rst", 32'h0000_0001, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect3("async_rst", 32'h0, 1'b0, 1'b0);
        A       = 32'h0000_0010;
        B       = 32'h0000_0020;
        ALU_Sel = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect3("post_rst", 32'h0000_0030, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
